// File: rtl/bcd_scoreboard.sv
// ---------------------------------------------------------------------------
// bcd_scoreboard
//
// Multi-digit packed-BCD score accumulator. Each enabled cycle, add_amt (BCD
// 0-9) is added to the least-significant digit. Carries ripple through every
// digit within the same clock. At full scale the score either wraps modulo
// 10^DIGITS (SATURATE = 0) or holds at all nines (SATURATE = 1). Either way
// a one-cycle overflow pulse is produced.
//
// Optional feature: define SCORE_HISCORE_EN to build the high-score tracker.
// When the macro is undefined, hiscore and new_high are tied to 0.
//
// Parameters:
//   DIGITS    number of BCD digits, 1-8
//   SATURATE  0 = wrap at full scale, 1 = saturate at all nines
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset; clears all state
//   clear      synchronous score clear; the high score is kept
//   add_valid  add add_amt to the score this cycle
//   add_amt    BCD amount 0-9; values 10-15 are rejected
//   bcd        current score, packed BCD, digit 0 in [3:0]
//   overflow   one-cycle pulse: the last add exceeded 10^DIGITS - 1
//   bad_amt    one-cycle pulse: an add with an illegal amount was rejected
//   hiscore    high score, packed BCD (0 when the feature is compiled out)
//   new_high   one-cycle pulse: hiscore was updated (0 when compiled out)
// ---------------------------------------------------------------------------
module bcd_scoreboard #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                add_valid,
  input  logic [3:0]          add_amt,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow,
  output logic                bad_amt,
  output logic [4*DIGITS-1:0] hiscore,
  output logic                new_high
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] sum_bcd;
  logic         carry_out;
  logic [W-1:0] next_score;
  logic         amt_legal;

  // Single-cycle ripple adder across all digits. Only digit 0 receives the
  // amount; the higher digits see nothing but the incoming carry.
  // NOTE: all outputs get defaults before the loop, so no latch is inferred.
  // The blocking '=' on s and c is intentional: each iteration reads the
  // carry that the previous digit just produced.
  always_comb begin
    logic [4:0] s;
    logic       c;
    sum_bcd = '0;
    s       = '0;
    c       = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, bcd[4*i +: 4]} + {4'b0000, c} + ((i == 0) ? {1'b0, add_amt} : 5'd0);
      if (s > 5'd9) begin
        sum_bcd[4*i +: 4] = 4'(s - 5'd10);
        c                 = 1'b1;
      end else begin
        sum_bcd[4*i +: 4] = s[3:0];
        c                 = 1'b0;
      end
    end
    carry_out = c;
  end

  assign amt_legal  = (add_amt <= 4'd9);
  assign next_score = (SATURATE && carry_out) ? {DIGITS{4'h9}} : sum_bcd;

  // Pulses default low every cycle and are raised only by the add path, so
  // clear and reset can never leave a stale pulse behind.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd      <= '0;
      overflow <= 1'b0;
      bad_amt  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      bad_amt  <= 1'b0;
      if (clear) begin
        bcd <= '0;
      end else if (add_valid) begin
        if (!amt_legal) begin
          bad_amt <= 1'b1;
        end else begin
          bcd      <= next_score;
          overflow <= carry_out;
        end
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  // The high score follows the registered score, so it lags bcd by one
  // cycle. An unsigned compare of packed BCD matches numeric order.
  logic [W-1:0] hiscore_q;
  logic         new_high_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore_q  <= '0;
      new_high_q <= 1'b0;
    end else begin
      new_high_q <= 1'b0;
      if (bcd > hiscore_q) begin
        hiscore_q  <= bcd;
        new_high_q <= 1'b1;
      end
    end
  end

  assign hiscore  = hiscore_q;
  assign new_high = new_high_q;
`else
  assign hiscore  = '0;
  assign new_high = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_bcd_scoreboard
//
// Drives a wrapping instance and a saturating instance (DIGITS = 4) with the
// same inputs. An integer reference model produces the expected values. They
// go into a queue when each cycle's stimulus is driven, and are popped and
// compared one cycle later, once the DUT outputs have settled.
// ---------------------------------------------------------------------------
module tb_bcd_scoreboard;

  localparam int DIGITS = 4;
  localparam int FULL   = 10000;

  logic        clk = 1'b0;
  logic        reset, clear, add_valid;
  logic [3:0]  add_amt;

  logic [15:0] w_bcd, w_hi, s_bcd, s_hi;
  logic        w_ovf, w_bad, w_nh, s_ovf, s_bad, s_nh;

  always #5 clk = ~clk;

  bcd_scoreboard #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .add_valid(add_valid),
    .add_amt(add_amt), .bcd(w_bcd), .overflow(w_ovf), .bad_amt(w_bad),
    .hiscore(w_hi), .new_high(w_nh)
  );

  bcd_scoreboard #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .add_valid(add_valid),
    .add_amt(add_amt), .bcd(s_bcd), .overflow(s_ovf), .bad_amt(s_bad),
    .hiscore(s_hi), .new_high(s_nh)
  );

  typedef struct {
    logic [15:0] bcd_w, bcd_s, hi_w, hi_s;
    logic        ovf_w, ovf_s, bad, nh_w, nh_s;
  } exp_t;

  typedef struct {
    logic        c, v;
    logic [3:0]  a;
    logic [15:0] e_bcd;
    logic        e_ovf, e_bad;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: integer scores and high scores.
  int m_w = 0, m_s = 0, mh_w = 0, mh_s = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, clock, then
  // pop the expectation and compare against both instances.
  task automatic step(input logic r, input logic c, input logic v, input logic [3:0] a);
    exp_t e;
    int   pw, ps, nw, ns;
    logic ovw, ovs, bad, nhw, nhs;
    reset = r; clear = c; add_valid = v; add_amt = a;
    pw = m_w; ps = m_s;
    ovw = 1'b0; ovs = 1'b0; bad = 1'b0; nhw = 1'b0; nhs = 1'b0;
    if (r) begin
      m_w = 0; m_s = 0; mh_w = 0; mh_s = 0;
    end else begin
      if (pw > mh_w) begin mh_w = pw; nhw = 1'b1; end
      if (ps > mh_s) begin mh_s = ps; nhs = 1'b1; end
      if (c) begin
        m_w = 0; m_s = 0;
      end else if (v) begin
        if (a > 4'd9) begin
          bad = 1'b1;
        end else begin
          nw = m_w + int'(a);
          ns = m_s + int'(a);
          if (nw >= FULL) begin ovw = 1'b1; nw = nw - FULL; end
          if (ns >= FULL) begin ovs = 1'b1; ns = FULL - 1; end
          m_w = nw; m_s = ns;
        end
      end
    end
    e.bcd_w = to_bcd(m_w); e.bcd_s = to_bcd(m_s);
    e.ovf_w = ovw; e.ovf_s = ovs; e.bad = bad;
`ifdef SCORE_HISCORE_EN
    e.hi_w = to_bcd(mh_w); e.hi_s = to_bcd(mh_s); e.nh_w = nhw; e.nh_s = nhs;
`else
    e.hi_w = '0; e.hi_s = '0; e.nh_w = 1'b0; e.nh_s = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("wrap_bcd", w_bcd, e.bcd_w);
    check("wrap_overflow", w_ovf, e.ovf_w);
    check("wrap_bad_amt", w_bad, e.bad);
    check("wrap_hiscore", w_hi, e.hi_w);
    check("wrap_new_high", w_nh, e.nh_w);
    check("sat_bcd", s_bcd, e.bcd_s);
    check("sat_overflow", s_ovf, e.ovf_s);
    check("sat_bad_amt", s_bad, e.bad);
    check("sat_hiscore", s_hi, e.hi_s);
    check("sat_new_high", s_nh, e.nh_s);
  endtask

  // Clear the score, then add up to target using nines plus a remainder.
  task automatic load(input int target);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    while (m_w + 9 <= target) step(1'b0, 1'b0, 1'b1, 4'd9);
    if (m_w < target) step(1'b0, 1'b0, 1'b1, 4'(target - m_w));
  endtask

  vec_t        tbl[17];
  logic [15:0] ones_exp[12];

  initial begin
    reset = 1'b1; clear = 1'b0; add_valid = 1'b0; add_amt = 4'd0;

    ones_exp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                 16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};
    for (int i = 0; i < 12; i++) tbl[i] = '{1'b0, 1'b1, 4'd1, ones_exp[i], 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'd12, 16'h0012, 1'b0, 1'b1};  // illegal amount rejected
    tbl[13] = '{1'b0, 1'b0, 4'd0,  16'h0012, 1'b0, 1'b0};  // idle: pulse gone
    tbl[14] = '{1'b0, 1'b1, 4'd15, 16'h0012, 1'b0, 1'b1};  // largest illegal amount
    tbl[15] = '{1'b1, 1'b1, 4'd4,  16'h0000, 1'b0, 1'b0};  // clear beats add
    tbl[16] = '{1'b0, 1'b1, 4'd3,  16'h0003, 1'b0, 1'b0};

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd5);
    check("reset_bcd", w_bcd, 16'h0000);

    // Table-driven basic adds, illegal amounts and clear priority.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, tbl[i].c, tbl[i].v, tbl[i].a);
      check("tbl_bcd", w_bcd, tbl[i].e_bcd);
      check("tbl_overflow", w_ovf, tbl[i].e_ovf);
      check("tbl_bad_amt", w_bad, tbl[i].e_bad);
    end

    // Full ripple across three digits.
    load(999);
    check("ripple_pre", w_bcd, 16'h0999);
    step(1'b0, 1'b0, 1'b1, 4'd7);
    check("ripple_bcd", w_bcd, 16'h1006);
    check("ripple_overflow", w_ovf, 1'b0);

    // Wrap vs saturate on the same overflowing add.
    load(9995);
    step(1'b0, 1'b0, 1'b1, 4'd9);
    check("wrap_result", w_bcd, 16'h0004);
    check("wrap_pulse", w_ovf, 1'b1);
    check("sat_result", s_bcd, 16'h9999);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    check("wrap_pulse_end", w_ovf, 1'b0);

    // Saturation: repeated adds keep pulsing, add of zero does not.
    load(9998);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    check("sat_first", s_bcd, 16'h9999);
    check("sat_first_ovf", s_ovf, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    check("sat_again_ovf", s_ovf, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("sat_zero_ovf", s_ovf, 1'b0);
    check("sat_zero_bcd", s_bcd, 16'h9999);

    // Reset overrides an overflowing add: no pulse.
    step(1'b1, 1'b0, 1'b1, 4'd9);
    check("rst_sat_bcd", s_bcd, 16'h0000);
    check("rst_sat_ovf", s_ovf, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0);

    // High-score tracking survives clear.
    load(42);
    step(1'b0, 1'b0, 1'b0, 4'd0);
`ifdef SCORE_HISCORE_EN
    check("hi_42", w_hi, 16'h0042);
    check("hi_42_pulse", w_nh, 1'b1);
`else
    check("hi_off", w_hi, 16'h0000);
`endif
    load(30);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
`ifdef SCORE_HISCORE_EN
    check("hi_kept", w_hi, 16'h0042);
`else
    check("hi_off_end", w_hi, 16'h0000);
`endif
    check("hi_no_pulse", w_nh, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
